// File: rtl/csr_bank_pkg.sv
// Shared register map, access classes and address decode for the csr_bank
// control/status register file.
package csr_bank_pkg;

   localparam logic [31:0] ADDR_ID         = 32'h00;
   localparam logic [31:0] ADDR_VER_MAJ    = 32'h01;
   localparam logic [31:0] ADDR_VER_MIN    = 32'h02;
   localparam logic [31:0] ADDR_EVT_STATUS = 32'h03;
   localparam logic [31:0] ADDR_EVT_ENABLE = 32'h04;
   localparam logic [31:0] ADDR_ERR_COUNT  = 32'h05;
   localparam logic [31:0] ADDR_SYS_CTRL   = 32'h06;
   localparam logic [31:0] ADDR_SCRATCH    = 32'h08;
   localparam logic [31:0] ADDR_LED        = 32'h20;
   localparam logic [31:0] ADDR_SW_IN      = 32'h22;

   typedef enum logic [2:0] {
      ACC_RO,
      ACC_RW,
      ACC_W1C,
      ACC_RC,
      ACC_NONE
   } csr_acc_e;

   function automatic csr_acc_e csr_acc(input logic [31:0] addr, input int unsigned n_scratch);
      csr_acc_e acc;
      acc = ACC_NONE;
      case (addr)
         ADDR_ID, ADDR_VER_MAJ, ADDR_VER_MIN, ADDR_SW_IN: acc = ACC_RO;
         ADDR_EVT_STATUS:                                 acc = ACC_W1C;
         ADDR_EVT_ENABLE, ADDR_SYS_CTRL, ADDR_LED:        acc = ACC_RW;
         ADDR_ERR_COUNT:                                  acc = ACC_RC;
         default:                                         acc = ACC_NONE;
      endcase
      if (addr >= ADDR_SCRATCH && addr < ADDR_SCRATCH + n_scratch)
         acc = ACC_RW;
      return acc;
   endfunction

endpackage

// File: rtl/csr_bank_sticky_evt.sv
// Sticky event status: rising-edge capture with W1C and soft-clear, where a
// new edge always beats a clear landing on the same bit in the same cycle.
module sticky_evt
   import csr_bank_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] evt_in,
   input  logic [N-1:0] w1c,
   input  logic         soft_clr,
   output logic [N-1:0] status
);

   logic [N-1:0] evt_prev;
   logic [N-1:0] set;
   logic [N-1:0] clr;

   assign set = evt_in & ~evt_prev;
   assign clr = w1c | {N{soft_clr}};

   // evt_prev resets high so sources already asserted at reset release stay quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_prev <= '1;
         status   <= '0;
      end else begin
         evt_prev <= evt_in;
         status   <= (status & ~clr) | set;
      end
   end

endmodule

// File: rtl/csr_bank.sv
// Control/status register bank behind the I2C slave register port: registered
// reads, W1C events with masked irq, saturating clear-on-read error counter.
module csr_bank
   import csr_bank_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned N_SCRATCH = 4,
   parameter int unsigned N_EVT     = 4,
   parameter logic [7:0]  DEVICE_ID = 8'hA7,
   parameter logic [7:0]  VER_MAJ   = 8'h02,
   parameter logic [7:0]  VER_MIN   = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0] reg_wdata,
   input  logic              reg_wr,
   input  logic              reg_rd,
   output logic [DATA_W-1:0] reg_rdata,
   output logic              reg_rvalid,
   output logic              reg_err,
   input  logic [N_EVT-1:0]  evt_in,
   input  logic              err_in,
   input  logic [DATA_W-1:0] sw_in,
   output logic [DATA_W-1:0] led_out,
   output logic              irq
);

   logic [31:0]       addr_x;
   csr_acc_e          acc;
   logic              wr_ok;
   logic              wr_bad;
   logic              rd_bad;
   logic              soft_clr;
   logic              rc_clr;
   logic [N_EVT-1:0]  w1c;
   logic [N_EVT-1:0]  evt_status;
   logic [N_EVT-1:0]  evt_en;
   logic [DATA_W-1:0] sys_ctrl;
   logic [DATA_W-1:0] scratch [N_SCRATCH];
   logic [DATA_W-1:0] err_cnt;
   logic [DATA_W-1:0] sw_meta;
   logic [DATA_W-1:0] sw_sync;
   logic [DATA_W-1:0] rd_mux;

   assign addr_x   = 32'(reg_addr);
   assign acc      = csr_acc(addr_x, N_SCRATCH);
   assign wr_ok    = reg_wr && (acc == ACC_RW || acc == ACC_W1C);
   assign wr_bad   = reg_wr && (acc == ACC_RO || acc == ACC_RC || acc == ACC_NONE);
   assign rd_bad   = reg_rd && (acc == ACC_NONE);
   assign soft_clr = wr_ok && addr_x == ADDR_SYS_CTRL && reg_wdata[0];
   assign rc_clr   = reg_rd && addr_x == ADDR_ERR_COUNT;
   assign w1c      = (wr_ok && addr_x == ADDR_EVT_STATUS) ? reg_wdata[N_EVT-1:0] : '0;

   sticky_evt #(.N(N_EVT)) u_evt (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_in   (evt_in),
      .w1c      (w1c),
      .soft_clr (soft_clr),
      .status   (evt_status)
   );

   always_comb begin
      rd_mux = '0;
      case (addr_x)
         ADDR_ID:         rd_mux = DATA_W'(DEVICE_ID);
         ADDR_VER_MAJ:    rd_mux = DATA_W'(VER_MAJ);
         ADDR_VER_MIN:    rd_mux = DATA_W'(VER_MIN);
         ADDR_EVT_STATUS: rd_mux[N_EVT-1:0] = evt_status;
         ADDR_EVT_ENABLE: rd_mux[N_EVT-1:0] = evt_en;
         ADDR_ERR_COUNT:  rd_mux = err_cnt;
         ADDR_SYS_CTRL:   rd_mux = sys_ctrl;
         ADDR_LED:        rd_mux = led_out;
         ADDR_SW_IN:      rd_mux = sw_sync;
         default:         rd_mux = '0;
      endcase
      for (int unsigned i = 0; i < N_SCRATCH; i++)
         if (addr_x == ADDR_SCRATCH + i) rd_mux = scratch[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_en   <= '0;
         sys_ctrl <= '0;
         led_out  <= '0;
         for (int unsigned i = 0; i < N_SCRATCH; i++) scratch[i] <= '0;
      end else if (wr_ok) begin
         if (addr_x == ADDR_EVT_ENABLE) evt_en <= reg_wdata[N_EVT-1:0];
         // bit0 is a strobe only; it never stays set
         if (addr_x == ADDR_SYS_CTRL)   sys_ctrl <= {reg_wdata[DATA_W-1:1], 1'b0};
         if (addr_x == ADDR_LED)        led_out <= reg_wdata;
         for (int unsigned i = 0; i < N_SCRATCH; i++)
            if (addr_x == ADDR_SCRATCH + i) scratch[i] <= reg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (soft_clr || rc_clr)
         err_cnt <= err_in ? DATA_W'(1) : '0;
      else if (err_in && err_cnt != '1)
         err_cnt <= err_cnt + DATA_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta    <= '0;
         sw_sync    <= '0;
         reg_rdata  <= '0;
         reg_rvalid <= 1'b0;
         reg_err    <= 1'b0;
         irq        <= 1'b0;
      end else begin
         sw_meta    <= sw_in;
         sw_sync    <= sw_meta;
         reg_rvalid <= reg_rd;
         reg_err    <= rd_bad || wr_bad;
         irq        <= |(evt_status & evt_en);
         if (reg_rd) reg_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_csr_bank.sv
// Directed scoreboard bench for csr_bank: default 8-bit instance plus a
// 16-bit / 12-event / 8-scratch instance.
module tb_csr_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        wr_a, rd_a, wr_b, rd_b;
   logic [3:0]  evt_a;
   logic        err_a;
   logic [7:0]  sw_a;
   logic [7:0]  rdata_a, led_a;
   logic        rvalid_a, rerr_a, irq_a;
   logic [11:0] evt_b;
   logic        err_b;
   logic [15:0] sw_b;
   logic [15:0] rdata_b, led_b;
   logic        rvalid_b, rerr_b, irq_b;

   logic [31:0] exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   csr_bank u_a (
      .clk(clk), .rst_n(rst_n), .reg_addr(addr), .reg_wdata(wdata[7:0]),
      .reg_wr(wr_a), .reg_rd(rd_a), .reg_rdata(rdata_a), .reg_rvalid(rvalid_a),
      .reg_err(rerr_a), .evt_in(evt_a), .err_in(err_a), .sw_in(sw_a),
      .led_out(led_a), .irq(irq_a)
   );

   csr_bank #(.DATA_W(16), .N_EVT(12), .N_SCRATCH(8)) u_b (
      .clk(clk), .rst_n(rst_n), .reg_addr(addr), .reg_wdata(wdata),
      .reg_wr(wr_b), .reg_rd(rd_b), .reg_rdata(rdata_b), .reg_rvalid(rvalid_b),
      .reg_err(rerr_b), .evt_in(evt_b), .err_in(err_b), .sw_in(sw_b),
      .led_out(led_b), .irq(irq_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_reg(input bit b, input logic [7:0] a, input logic [31:0] exp,
                         input logic exp_err, input logic pulse_err);
      logic [31:0] got;
      @(negedge clk);
      addr  = a;
      err_a = pulse_err;
      if (b) rd_b = 1'b1; else rd_a = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      rd_a  = 1'b0;
      rd_b  = 1'b0;
      err_a = 1'b0;
      chk($sformatf("rvalid_%0d_%02h", b, a), 32'(b ? rvalid_b : rvalid_a), 32'd1);
      got = exp_q.pop_front();
      chk($sformatf("rdata_%0d_%02h", b, a), b ? 32'(rdata_b) : 32'(rdata_a), got);
      chk($sformatf("rerr_%0d_%02h", b, a), 32'(b ? rerr_b : rerr_a), 32'(exp_err));
   endtask

   task automatic wr_reg(input bit b, input logic [7:0] a, input logic [15:0] d,
                         input logic exp_err);
      @(negedge clk);
      addr  = a;
      wdata = d;
      if (b) wr_b = 1'b1; else wr_a = 1'b1;
      @(negedge clk);
      wr_a = 1'b0;
      wr_b = 1'b0;
      chk($sformatf("werr_%0d_%02h", b, a), 32'(b ? rerr_b : rerr_a), 32'(exp_err));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      addr = '0; wdata = '0;
      wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
      evt_a = '1; err_a = 0; sw_a = '0;
      evt_b = '0; err_b = 0; sw_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_outs_a", {rdata_a, led_a, 13'd0, rvalid_a, rerr_a, irq_a}, 32'd0);
      chk("rst_outs_b", {rdata_b, led_b}, 32'd0);
      chk("rst_flags_b", {29'd0, rvalid_b, rerr_b, irq_b}, 32'd0);
      rst_n = 1'b1;

      rd_reg(0, 8'h00, 32'hA7, 0, 0);
      rd_reg(0, 8'h01, 32'h02, 0, 0);
      @(negedge clk);
      chk("rvalid_idle", 32'(rvalid_a), 32'd0);
      chk("rdata_hold", 32'(rdata_a), 32'h02);
      rd_reg(0, 8'h02, 32'h00, 0, 0);
      rd_reg(0, 8'h03, 32'h00, 0, 0);
      evt_a = '0;

      wr_reg(0, 8'h08, 16'h005A, 0);
      wr_reg(0, 8'h20, 16'h003C, 0);
      rd_reg(0, 8'h08, 32'h5A, 0, 0);
      rd_reg(0, 8'h20, 32'h3C, 0, 0);
      chk("led_out", 32'(led_a), 32'h3C);
      wr_reg(0, 8'h00, 16'h00A5, 1);
      rd_reg(0, 8'h7F, 32'h00, 1, 0);
      rd_reg(0, 8'h00, 32'hA7, 0, 0);
      wr_reg(0, 8'h05, 16'h0011, 1);

      wr_reg(0, 8'h04, 16'h0001, 0);
      @(negedge clk);
      evt_a = 4'b0001;
      @(negedge clk);
      chk("irq_n1", 32'(irq_a), 32'd0);
      @(negedge clk);
      chk("irq_n2", 32'(irq_a), 32'd1);
      rd_reg(0, 8'h03, 32'h01, 0, 0);
      @(negedge clk);
      evt_a = 4'b0000;
      @(negedge clk);
      addr = 8'h03; wdata = 16'h0001; wr_a = 1'b1; evt_a = 4'b0001;
      @(negedge clk);
      wr_a = 1'b0;
      rd_reg(0, 8'h03, 32'h01, 0, 0);
      chk("irq_set_wins", 32'(irq_a), 32'd1);
      wr_reg(0, 8'h03, 16'h0001, 0);
      chk("irq_before_drop", 32'(irq_a), 32'd1);
      @(negedge clk);
      chk("irq_dropped", 32'(irq_a), 32'd0);
      rd_reg(0, 8'h03, 32'h00, 0, 0);
      evt_a = 4'b0011;
      rd_reg(0, 8'h03, 32'h02, 0, 0);
      chk("irq_masked", 32'(irq_a), 32'd0);

      @(negedge clk);
      err_a = 1'b1;
      repeat (300) @(negedge clk);
      err_a = 1'b0;
      rd_reg(0, 8'h05, 32'hFF, 0, 0);
      rd_reg(0, 8'h05, 32'h00, 0, 0);
      @(negedge clk);
      err_a = 1'b1;
      repeat (2) @(negedge clk);
      err_a = 1'b0;
      rd_reg(0, 8'h05, 32'h02, 0, 1);
      rd_reg(0, 8'h05, 32'h01, 0, 0);

      @(negedge clk);
      err_a = 1'b1;
      @(negedge clk);
      err_a = 1'b0;
      wr_reg(0, 8'h06, 16'h0081, 0);
      rd_reg(0, 8'h06, 32'h80, 0, 0);
      rd_reg(0, 8'h05, 32'h00, 0, 0);
      rd_reg(0, 8'h03, 32'h00, 0, 0);

      @(negedge clk);
      sw_a = 8'h96;
      rd_reg(0, 8'h22, 32'h00, 0, 0);
      rd_reg(0, 8'h22, 32'h96, 0, 0);

      @(negedge clk);
      addr = 8'h20; rd_a = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rd_a = 1'b0;
      chk("rst_mid_rvalid", 32'(rvalid_a), 32'd0);
      chk("rst_mid_outs", {rdata_a, led_a, 15'd0, irq_a}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid_a), 32'd0);
      rd_reg(0, 8'h20, 32'h00, 0, 0);
      rd_reg(0, 8'h08, 32'h00, 0, 0);
      rd_reg(0, 8'h04, 32'h00, 0, 0);
      rd_reg(0, 8'h06, 32'h00, 0, 0);
      rd_reg(0, 8'h03, 32'h00, 0, 0);

      wr_reg(1, 8'h0F, 16'hBEEF, 0);
      rd_reg(1, 8'h0F, 32'hBEEF, 0, 0);
      rd_reg(1, 8'h10, 32'h0000, 1, 0);
      wr_reg(1, 8'h10, 16'h1234, 1);
      rd_reg(1, 8'h00, 32'h00A7, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_bank.md
# csr_bank

Parametrised control/status register bank on the I2C control plane: second-generation register file with configurable data width, scratch depth and event channel count. Adds registered read handshake, W1C sticky event status, interrupt enable mask with registered `irq`, saturating clear-on-read error counter, unmapped-access flagging and synchronised switch input. Sits between the I2C slave register port and board GPIO/data-plane status.

## Interface
- `DATA_W`, 8: register width; legal range 8..32.
- `ADDR_W`, 8: register address width.
- `N_SCRATCH`, 4: scratch registers at 0x08..0x08+N_SCRATCH-1; legal range 1..8.
- `N_EVT`, 4: event channels; legal range 1..DATA_W.
- `DEVICE_ID`, 8'hA7: value of ID register, zero-extended to DATA_W.
- `VER_MAJ` / `VER_MIN`, 8'h02 / 8'h00: version registers.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `reg_addr` in ADDR_W: register address.
- `reg_wdata` in DATA_W: write data.
- `reg_wr` in 1: write strobe, one cycle.
- `reg_rd` in 1: read strobe, one cycle.
- `reg_rdata` out DATA_W: registered read data.
- `reg_rvalid` out 1: one-cycle pulse qualifying `reg_rdata`.
- `reg_err` out 1: one-cycle pulse on access to an unmapped or read-only-for-write address.
- `evt_in` in N_EVT: synchronous event sources, rising-edge detected.
- `err_in` in 1: error pulse to be counted.
- `sw_in` in DATA_W: asynchronous switch inputs.
- `led_out` out DATA_W: LED register.
- `irq` out 1: registered interrupt, active high.

## Operation
- Map:
  - 0x00 ID (RO)
  - 0x01 VER_MAJ (RO)
  - 0x02 VER_MIN (RO)
  - 0x03 EVT_STATUS (W1C; bits ≥ N_EVT read 0)
  - 0x04 EVT_ENABLE (RW; N_EVT bits)
  - 0x05 ERR_COUNT (RO, clear-on-read)
  - 0x06 SYS_CTRL (RW; bit0 = soft-clear, self-clearing, reads 0)
  - 0x08+ SCRATCH (RW)
  - 0x20 LED (RW)
  - 0x22 SW_IN (RO, synchronised)
  - All other addresses: read 0.
- `reg_err` fires for:
  - a read of an unmapped address;
  - a write to an unmapped or RO address. The write is discarded.
- Event detect: `evt_prev` register, reset to all-ones, so inputs already high at reset release do not fire. A rising edge sets the corresponding sticky bit in EVT_STATUS.
- W1C: writing 1 clears the bit; writing 0 leaves it unchanged. If a set and a clear hit the same bit in the same cycle, set wins.
- Soft-clear (SYS_CTRL bit0 written 1):
  - clears EVT_STATUS and ERR_COUNT in that cycle;
  - a coincident event set still wins.
- ERR_COUNT: width DATA_W; +1 per `err_in` cycle; saturates at all-ones and never wraps.
  - A read returns the pre-clear value and clears the counter.
  - If `err_in` arrives in the read cycle, the counter ends at 1.
- `irq` = registered OR of (EVT_STATUS & EVT_ENABLE).
- SW_IN: 2-flop synchroniser, reset 0.

## Timing
- Read: `reg_rd` in cycle N produces `reg_rdata` + `reg_rvalid` in N+1.
  - `reg_rdata` holds its value until the next read.
  - `reg_rvalid` is low otherwise.
- Write: applied at the edge ending the `reg_wr` cycle. A read issued in the next cycle returns the new value.
- `reg_wr` and `reg_rd` in the same cycle:
  - the read returns the pre-write value;
  - the write is applied;
  - if both are erroneous, `reg_err` is a single pulse in N+1.
- `reg_err` is aligned with N+1 for both reads and writes.
- Event path: edge at `evt_in` in cycle N → status bit set at N+1 → `irq` at N+2 (if enabled).
- `irq` deasserts one cycle after the clearing write or enable drop.
- SW_IN value is visible to reads 2 cycles after an input change.
- Reset (async, any time, including mid-read): all outputs 0 (`reg_rdata`, `reg_rvalid`, `reg_err`, `led_out`, `irq`). All RW registers reset to 0. An in-flight read is dropped with no `reg_rvalid`.

## Structure
- Package `csr_bank_pkg`:
  - address localparams;
  - access-type enum `csr_acc_e` {ACC_RO, ACC_RW, ACC_W1C, ACC_RC, ACC_NONE};
  - function `csr_acc(addr)` used for decode and `reg_err`.
- Sub-module `sticky_evt` (parameter N): edge detect, sticky set/W1C/soft-clear with set priority; instantiated once with N = N_EVT.
- Top: decode, RW registers, saturating counter, synchroniser, read pipeline register, `irq` register.

## Test plan
- Reset, then read 0x00/0x01/0x02 → 0xA7/0x02/0x00, each with `reg_rvalid` exactly 1 cycle after `reg_rd`; all outputs 0 during reset.
- Write SCRATCH0=0x5A and LED=0x3C, read back → 0x5A, 0x3C; `led_out`=0x3C. Write 0x00 (RO) and read 0x7F → `reg_err` pulses, read data 0, ID unchanged.
- EVT_ENABLE=0x1, edge on `evt_in[0]` → EVT_STATUS=0x1, `irq` high 2 cycles after the edge. W1C 0x1 in the same cycle as a new edge → bit stays set. A later W1C → `irq` low the next cycle.
- 300 `err_in` pulses at DATA_W=8 → ERR_COUNT reads 0xFF; the next read → 0x00. An `err_in` coincident with the clearing read → the following read returns 0x01.
- Hold `evt_in`=all-ones across reset release → no status bits set. Assert `rst_n` low between `reg_rd` and `reg_rvalid` → no rvalid, all registers 0.
- Regression at DATA_W=16, N_EVT=12, N_SCRATCH=8: scratch 0x0F (last index) reads back 0xBEEF; address 0x10 flags `reg_err`.
